// File: rtl/input_event_unit.sv
// ---------------------------------------------------------------------------
// input_event_unit
//
// Front end for the bicycle computer's pushbuttons and Hall-effect sensors.
// Each active-low pad is synchronised, debounced and turned into one-cycle
// press / release / long-press pulses. Every pulse is latched in a per-channel
// pending bit, and a fixed-priority arbiter moves one pending event per cycle
// into an event FIFO. The processor pops the FIFO with a valid/ready handshake.
//
// Ports
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   nIn        in   [NUM_CH]  raw active-low pad inputs
//   Stable     out  [NUM_CH]  debounced level, 1 = asserted
//   Press      out  [NUM_CH]  one-cycle pulse on debounced assertion
//   Release    out  [NUM_CH]  one-cycle pulse on debounced deassertion
//   LongPress  out  [NUM_CH]  one-cycle pulse after LONG_CYCLES of hold
//   EvValid    out  FIFO non-empty
//   EvData     out  head entry {channel, type[1:0]} (+ timestamp with option)
//                   type: 00 press, 01 release, 10 long press
//   EvReady    in   pop strobe, ignored while EvValid = 0
//   EvCount    out  FIFO occupancy
//   Overflow   out  sticky: an event was dropped on a pending-bit collision
//   OvfClear   in   clears Overflow (a new collision in the same cycle wins)
//
// Optional feature: define TIMESTAMP_EN to add a free-running TS_W-bit
// timestamp counter. Each event carries the counter value captured in the
// cycle its pulse fired, appended as EvData[TS_W-1:0].
// ---------------------------------------------------------------------------
module input_event_unit #(
   parameter int NUM_CH      = 5,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 8,
   parameter int DEB_CYCLES  = 33,
   parameter int LONG_W      = 16,
   parameter int LONG_CYCLES = 32768,
   parameter int FIFO_DEPTH  = 8,
`ifdef TIMESTAMP_EN
   parameter int TS_W        = 16,
   localparam int EW         = $clog2(NUM_CH) + 2 + TS_W,
`else
   localparam int EW         = $clog2(NUM_CH) + 2,
`endif
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [NUM_CH-1:0] nIn,
   output logic [NUM_CH-1:0] Stable,
   output logic [NUM_CH-1:0] Press,
   output logic [NUM_CH-1:0] Release,
   output logic [NUM_CH-1:0] LongPress,
   output logic              EvValid,
   output logic [EW-1:0]     EvData,
   input  logic              EvReady,
   output logic [CW-1:0]     EvCount,
   output logic              Overflow,
   input  logic              OvfClear
);

   localparam int CHW = $clog2(NUM_CH);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int NEV = NUM_CH * 3;           // three pending bits per channel
   localparam int IW  = $clog2(NEV);

   // synchroniser and per-channel state
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
   logic [NUM_CH-1:0]                  sync_out;
   logic [NUM_CH-1:0][DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
   logic [NUM_CH-1:0][LONG_W-1:0]      hold_q, hold_d;
   logic [NUM_CH-1:0]                  stable_q, stable_d;
   logic [NUM_CH-1:0]                  press_q, press_d;
   logic [NUM_CH-1:0]                  release_q, release_d;
   logic [NUM_CH-1:0]                  long_q, long_d;

   // pending bits and arbiter
   logic [NEV-1:0]                     pending_q, pending_d;
   logic [NEV-1:0]                     ev_pulse, grant, collide;
   logic [IW-1:0]                      g_idx;
   logic [CHW-1:0]                     g_ch;
   logic [1:0]                         g_type;
   logic                               ovf_q, ovf_d;

   // event FIFO
   logic [FIFO_DEPTH-1:0][EW-1:0]      mem_q, mem_d;
   logic [PW-1:0]                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                      count_q, count_d;
   logic                               ev_valid_q, ev_valid_d;
   logic [EW-1:0]                      ev_data_q, ev_data_d;
   logic [EW-1:0]                      push_data;
   logic                               push, pop, full;

`ifdef TIMESTAMP_EN
   logic [TS_W-1:0]                    ts_q, ts_d;
   logic [NEV-1:0][TS_W-1:0]           stamp_q, stamp_d;
`endif

   // Synchroniser shift chain; asserted level is the inverted pad.
   always_comb begin
      sync_d[0] = ~nIn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
      sync_out = sync_q[SYNC_STAGES-1];
   end

   // Debounce, edge pulses and hold counter for every channel.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         stable_d[i] = stable_q[i];
         if (sync_out[i] == stable_q[i]) begin
            deb_cnt_d[i] = {DEB_W{1'b0}};
         end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
            stable_d[i]  = ~stable_q[i];
            deb_cnt_d[i] = {DEB_W{1'b0}};
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
         end

         press_d[i]   = stable_d[i] & ~stable_q[i];
         release_d[i] = ~stable_d[i] & stable_q[i];

         // Saturates at all-ones, so the LONG_CYCLES-1 match is seen only
         // once per hold and LongPress never repeats.
         if (!stable_q[i]) begin
            hold_d[i] = {LONG_W{1'b0}};
         end else if (hold_q[i] != {LONG_W{1'b1}}) begin
            hold_d[i] = hold_q[i] + LONG_W'(1);
         end else begin
            hold_d[i] = hold_q[i];
         end

         // stable_d gate: a release in the same cycle suppresses LongPress.
         long_d[i] = stable_q[i] & stable_d[i] &
                     (hold_q[i] == LONG_W'(LONG_CYCLES - 1));

         ev_pulse[i*3+0] = press_q[i];
         ev_pulse[i*3+1] = release_q[i];
         ev_pulse[i*3+2] = long_q[i];
      end
   end

   // Arbiter, pending-bit update and overflow flag.
   always_comb begin
      // Descending scan so the lowest set bit is the last one written.
      g_idx = {IW{1'b0}};
      for (int k = NEV - 1; k >= 0; k--) begin
         g_idx = pending_q[k] ? IW'(k) : g_idx;
      end
      g_ch   = CHW'(g_idx / IW'(3));
      g_type = 2'(g_idx % IW'(3));

      pop  = EvReady & (count_q != {CW{1'b0}});
      full = (count_q == CW'(FIFO_DEPTH));
      // A simultaneous pop frees a slot even when the FIFO is full.
      push = (|pending_q) & (~full | pop);

      for (int k = 0; k < NEV; k++) begin
         grant[k] = push & (g_idx == IW'(k));
      end

      // A bit being pushed this cycle is free to take a new pulse.
      collide   = ev_pulse & pending_q & ~grant;
      pending_d = (pending_q & ~grant) | ev_pulse;
      ovf_d     = (|collide) ? 1'b1 : (OvfClear ? 1'b0 : ovf_q);
   end

`ifdef TIMESTAMP_EN
   // Free-running timestamp and per-event capture on accepted pulses.
   always_comb begin
      ts_d = ts_q + TS_W'(1);
      for (int k = 0; k < NEV; k++) begin
         stamp_d[k] = (ev_pulse[k] & ~collide[k]) ? ts_q : stamp_q[k];
      end
      push_data = {g_ch, g_type, stamp_q[g_idx]};
   end
`else
   // Entry format without timestamp.
   always_comb begin
      push_data = {g_ch, g_type};
   end
`endif

   // FIFO pointers, storage and registered head/valid.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         mem_d[k] = (push && (wr_ptr_q == PW'(k))) ? push_data : mem_q[k];
      end
      ev_valid_d = (count_d != {CW{1'b0}});
      // The entry being written lands at the new head only when it becomes
      // the sole occupant; otherwise the head comes from storage.
      ev_data_d  = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
   end

   // State registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync_q     <= {(SYNC_STAGES*NUM_CH){1'b0}};
         deb_cnt_q  <= {(NUM_CH*DEB_W){1'b0}};
         hold_q     <= {(NUM_CH*LONG_W){1'b0}};
         stable_q   <= {NUM_CH{1'b0}};
         press_q    <= {NUM_CH{1'b0}};
         release_q  <= {NUM_CH{1'b0}};
         long_q     <= {NUM_CH{1'b0}};
         pending_q  <= {NEV{1'b0}};
         ovf_q      <= 1'b0;
         mem_q      <= {(FIFO_DEPTH*EW){1'b0}};
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         ev_valid_q <= 1'b0;
         ev_data_q  <= {EW{1'b0}};
      end else begin
         sync_q     <= sync_d;
         deb_cnt_q  <= deb_cnt_d;
         hold_q     <= hold_d;
         stable_q   <= stable_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
         pending_q  <= pending_d;
         ovf_q      <= ovf_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ev_valid_q <= ev_valid_d;
         ev_data_q  <= ev_data_d;
      end
   end

`ifdef TIMESTAMP_EN
   // Timestamp registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ts_q    <= {TS_W{1'b0}};
         stamp_q <= {(NEV*TS_W){1'b0}};
      end else begin
         ts_q    <= ts_d;
         stamp_q <= stamp_d;
      end
   end
`endif

   assign Stable    = stable_q;
   assign Press     = press_q;
   assign Release   = release_q;
   assign LongPress = long_q;
   assign EvValid   = ev_valid_q;
   assign EvData    = ev_data_q;
   assign EvCount   = count_q;
   assign Overflow  = ovf_q;

endmodule

// File: tb/tb_input_event_unit.sv
// Directed bench for input_event_unit. dut1 uses an 8-entry FIFO, dut2 a
// 2-entry FIFO for the full/overflow scenario. Both use DEB_CYCLES=4,
// SYNC_STAGES=2 and LONG_CYCLES=20. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_input_event_unit;

`ifdef TIMESTAMP_EN
   localparam int EW = 3 + 2 + 16;
`else
   localparam int EW = 3 + 2;
`endif

   logic          Clock = 1'b0;
   logic          Reset;
   logic [4:0]    nin1, nin2;
   logic [4:0]    stable1, press1, release1, long1;
   logic [4:0]    stable2, press2, release2, long2;
   logic          ev_valid1, ev_valid2, ev_ready1, ev_ready2;
   logic [EW-1:0] ev_data1, ev_data2;
   logic [3:0]    ev_count1;
   logic [1:0]    ev_count2;
   logic          overflow1, overflow2, ovf_clear1, ovf_clear2;
   logic [4:0]    head1, head2;

   int checks = 0;
   int passes = 0;

   assign head1 = ev_data1[EW-1 -: 5];
   assign head2 = ev_data2[EW-1 -: 5];

   always #5 Clock = ~Clock;

   input_event_unit #(.NUM_CH(5), .SYNC_STAGES(2), .DEB_W(8), .DEB_CYCLES(4),
                      .LONG_W(16), .LONG_CYCLES(20), .FIFO_DEPTH(8)) dut1 (
      .Clock(Clock), .Reset(Reset), .nIn(nin1), .Stable(stable1), .Press(press1),
      .Release(release1), .LongPress(long1), .EvValid(ev_valid1), .EvData(ev_data1),
      .EvReady(ev_ready1), .EvCount(ev_count1), .Overflow(overflow1), .OvfClear(ovf_clear1));

   input_event_unit #(.NUM_CH(5), .SYNC_STAGES(2), .DEB_W(8), .DEB_CYCLES(4),
                      .LONG_W(16), .LONG_CYCLES(20), .FIFO_DEPTH(2)) dut2 (
      .Clock(Clock), .Reset(Reset), .nIn(nin2), .Stable(stable2), .Press(press2),
      .Release(release2), .LongPress(long2), .EvValid(ev_valid2), .EvData(ev_data2),
      .EvReady(ev_ready2), .EvCount(ev_count2), .Overflow(overflow2), .OvfClear(ovf_clear2));

`ifdef TIMESTAMP_EN
   logic [15:0] tb_cyc;
   // Reference cycle counter matching the free-running timestamp.
   always @(posedge Clock) begin
      if (Reset) tb_cyc <= 16'd0;
      else       tb_cyc <= tb_cyc + 16'd1;
   end
`endif

   function automatic logic [4:0] ent(input logic [2:0] ch, input logic [1:0] ty);
      return {ch, ty};
   endfunction

   task automatic pop1();
      ev_ready1 = 1'b1;
      @(negedge Clock);
      ev_ready1 = 1'b0;
   endtask

   task automatic pop2();
      ev_ready2 = 1'b1;
      @(negedge Clock);
      ev_ready2 = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      checks++; if (stable1 !== 5'b0) $display("FAIL reset_stable got %b want %b", stable1, 5'b0); else passes++;
      checks++; if ({press1, release1, long1} !== 15'b0) $display("FAIL reset_pulses got %b want 0", {press1, release1, long1}); else passes++;
      checks++; if (ev_valid1 !== 1'b0) $display("FAIL reset_valid got %b want 0", ev_valid1); else passes++;
      checks++; if (ev_count1 !== 4'd0) $display("FAIL reset_count got %0d want 0", ev_count1); else passes++;
      checks++; if (overflow1 !== 1'b0 || overflow2 !== 1'b0) $display("FAIL reset_ovf got %b%b want 00", overflow1, overflow2); else passes++;
   endtask

   task automatic test_press_latency();
      nin1[3] = 1'b0;
      repeat (5) @(negedge Clock);
      checks++; if (stable1[3] !== 1'b0) $display("FAIL lat_early got %b want 0", stable1[3]); else passes++;
      @(negedge Clock);
      checks++; if (stable1 !== 5'b01000) $display("FAIL lat_stable got %b want %b", stable1, 5'b01000); else passes++;
      checks++; if (press1 !== 5'b01000) $display("FAIL lat_press got %b want %b", press1, 5'b01000); else passes++;
      @(negedge Clock);
      checks++; if (press1 !== 5'b0 || stable1 !== 5'b01000) $display("FAIL lat_pulse_width press %b stable %b want 00000 01000", press1, stable1); else passes++;
      @(negedge Clock);
      checks++; if (ev_valid1 !== 1'b1) $display("FAIL lat_valid got %b want 1", ev_valid1); else passes++;
      checks++; if (head1 !== ent(3'd3, 2'd0)) $display("FAIL lat_data got %b want %b", head1, ent(3'd3, 2'd0)); else passes++;
      checks++; if (ev_count1 !== 4'd1) $display("FAIL lat_count got %0d want 1", ev_count1); else passes++;
      nin1[3] = 1'b1;
      repeat (5) @(negedge Clock);
      checks++; if (release1 !== 5'b0) $display("FAIL rel_early got %b want 0", release1); else passes++;
      @(negedge Clock);
      checks++; if (release1 !== 5'b01000 || stable1 !== 5'b0) $display("FAIL rel_pulse rel %b stable %b want 01000 00000", release1, stable1); else passes++;
      repeat (2) @(negedge Clock);
      checks++; if (ev_count1 !== 4'd2) $display("FAIL rel_count got %0d want 2", ev_count1); else passes++;
      pop1();
      checks++; if (head1 !== ent(3'd3, 2'd1)) $display("FAIL rel_data got %b want %b", head1, ent(3'd3, 2'd1)); else passes++;
      checks++; if (ev_count1 !== 4'd1) $display("FAIL rel_count_pop got %0d want 1", ev_count1); else passes++;
      pop1();
      checks++; if (ev_valid1 !== 1'b0 || ev_count1 !== 4'd0) $display("FAIL lat_empty valid %b count %0d want 0 0", ev_valid1, ev_count1); else passes++;
      // pop on empty FIFO is ignored
      pop1();
      checks++; if (ev_count1 !== 4'd0) $display("FAIL empty_pop count got %0d want 0", ev_count1); else passes++;
   endtask

   task automatic test_glitch();
      logic seen;
      seen = 1'b0;
      nin1[0] = 1'b0;
      repeat (2) @(negedge Clock);
      nin1[0] = 1'b1;
      for (int n = 0; n < 15; n++) begin
         @(negedge Clock);
         seen = seen | stable1[0] | press1[0] | ev_valid1;
      end
      checks++; if (seen !== 1'b0) $display("FAIL glitch2 got activity %b want 0", seen); else passes++;
      nin1[0] = 1'b0;
      repeat (3) @(negedge Clock);
      nin1[0] = 1'b1;
      for (int n = 0; n < 15; n++) begin
         @(negedge Clock);
         seen = seen | stable1[0] | press1[0] | ev_valid1;
      end
      checks++; if (seen !== 1'b0) $display("FAIL glitch3 got activity %b want 0", seen); else passes++;
   endtask

   task automatic test_long_press();
      int cyc;
      int extra;
      cyc = 0;
      extra = 0;
      nin1[1] = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (press1[1]) break;
      end
      checks++; if (press1[1] !== 1'b1) $display("FAIL long_press_seen got %b want 1", press1[1]); else passes++;
      for (int n = 0; n < 40; n++) begin
         @(negedge Clock);
         if (long1[1]) begin
            cyc = n + 1;
            break;
         end
      end
      checks++; if (cyc !== 20) $display("FAIL long_delay got %0d want 20", cyc); else passes++;
      for (int n = 0; n < 30; n++) begin
         @(negedge Clock);
         if (long1 != 5'b0) extra++;
      end
      checks++; if (extra !== 0) $display("FAIL long_repeat got %0d want 0", extra); else passes++;
      checks++; if (ev_count1 !== 4'd2) $display("FAIL long_count got %0d want 2", ev_count1); else passes++;
      checks++; if (head1 !== ent(3'd1, 2'd0)) $display("FAIL long_e0 got %b want %b", head1, ent(3'd1, 2'd0)); else passes++;
      pop1();
      checks++; if (head1 !== ent(3'd1, 2'd2)) $display("FAIL long_e1 got %b want %b", head1, ent(3'd1, 2'd2)); else passes++;
      pop1();
      nin1[1] = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (release1[1]) break;
      end
      checks++; if (release1[1] !== 1'b1) $display("FAIL long_release got %b want 1", release1[1]); else passes++;
      repeat (3) @(negedge Clock);
      checks++; if (head1 !== ent(3'd1, 2'd1) || ev_valid1 !== 1'b1) $display("FAIL long_e2 got %b valid %b want %b 1", head1, ev_valid1, ent(3'd1, 2'd1)); else passes++;
      pop1();
      checks++; if (ev_valid1 !== 1'b0) $display("FAIL long_empty got %b want 0", ev_valid1); else passes++;
   endtask

   task automatic test_simultaneous();
      nin1[0] = 1'b0;
      nin1[4] = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (ev_valid1) break;
      end
      checks++; if (head1 !== ent(3'd0, 2'd0) || ev_count1 !== 4'd1) $display("FAIL simul_first got %b count %0d want %b 1", head1, ev_count1, ent(3'd0, 2'd0)); else passes++;
      @(negedge Clock);
      checks++; if (ev_count1 !== 4'd2 || head1 !== ent(3'd0, 2'd0)) $display("FAIL simul_second count %0d head %b want 2 %b", ev_count1, head1, ent(3'd0, 2'd0)); else passes++;
      pop1();
      checks++; if (head1 !== ent(3'd4, 2'd0)) $display("FAIL simul_ch4 got %b want %b", head1, ent(3'd4, 2'd0)); else passes++;
      pop1();
      nin1[0] = 1'b1;
      nin1[4] = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (release1 != 5'b0) break;
      end
      checks++; if (release1 !== 5'b10001) $display("FAIL simul_release got %b want %b", release1, 5'b10001); else passes++;
      repeat (3) @(negedge Clock);
      checks++; if (ev_count1 !== 4'd2 || head1 !== ent(3'd0, 2'd1)) $display("FAIL simul_rel0 count %0d head %b want 2 %b", ev_count1, head1, ent(3'd0, 2'd1)); else passes++;
      pop1();
      checks++; if (head1 !== ent(3'd4, 2'd1)) $display("FAIL simul_rel4 got %b want %b", head1, ent(3'd4, 2'd1)); else passes++;
      pop1();
   endtask

   task automatic test_overflow();
      logic [4:0] exp_ev [8];
      exp_ev[0] = ent(3'd0, 2'd0);
      exp_ev[1] = ent(3'd1, 2'd0);
      exp_ev[2] = ent(3'd0, 2'd1);
      exp_ev[3] = ent(3'd1, 2'd1);
      exp_ev[4] = ent(3'd2, 2'd0);
      exp_ev[5] = ent(3'd2, 2'd1);
      exp_ev[6] = ent(3'd3, 2'd0);
      exp_ev[7] = ent(3'd3, 2'd1);
      nin2[3:0] = 4'b0000;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (press2 == 5'b01111) break;
      end
      checks++; if (press2 !== 5'b01111) $display("FAIL ovf_press got %b want %b", press2, 5'b01111); else passes++;
      repeat (4) @(negedge Clock);
      checks++; if (ev_count2 !== 2'd2 || head2 !== ent(3'd0, 2'd0)) $display("FAIL ovf_full count %0d head %b want 2 %b", ev_count2, head2, ent(3'd0, 2'd0)); else passes++;
      nin2[3:0] = 4'b1111;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (release2 == 5'b01111) break;
      end
      checks++; if (release2 !== 5'b01111) $display("FAIL ovf_release got %b want %b", release2, 5'b01111); else passes++;
      repeat (3) @(negedge Clock);
      checks++; if (ev_count2 !== 2'd2 || overflow2 !== 1'b0) $display("FAIL ovf_held count %0d ovf %b want 2 0", ev_count2, overflow2); else passes++;
      nin2[2] = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (press2[2]) break;
      end
      checks++; if (press2[2] !== 1'b1 || overflow2 !== 1'b0) $display("FAIL ovf_repress press %b ovf %b want 1 0", press2[2], overflow2); else passes++;
      @(negedge Clock);
      checks++; if (overflow2 !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow2); else passes++;
      ovf_clear2 = 1'b1;
      @(negedge Clock);
      checks++; if (overflow2 !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow2); else passes++;
      nin2[2] = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (release2[2]) break;
      end
      checks++; if (release2[2] !== 1'b1 || overflow2 !== 1'b0) $display("FAIL ovf_rerelease rel %b ovf %b want 1 0", release2[2], overflow2); else passes++;
      @(negedge Clock);
      checks++; if (overflow2 !== 1'b1) $display("FAIL ovf_set_priority got %b want 1", overflow2); else passes++;
      @(negedge Clock);
      checks++; if (overflow2 !== 1'b0) $display("FAIL ovf_clear_after got %b want 0", overflow2); else passes++;
      ovf_clear2 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 10; n++) begin
            if (ev_valid2) break;
            @(negedge Clock);
         end
         checks++; if (ev_valid2 !== 1'b1 || head2 !== exp_ev[k]) $display("FAIL ovf_read%0d valid %b got %b want %b", k, ev_valid2, head2, exp_ev[k]); else passes++;
         pop2();
      end
      repeat (2) @(negedge Clock);
      checks++; if (ev_valid2 !== 1'b0 || ev_count2 !== 2'd0) $display("FAIL ovf_drained valid %b count %0d want 0 0", ev_valid2, ev_count2); else passes++;
   endtask

   task automatic test_reset_mid();
      nin1[2] = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (ev_valid1) break;
      end
      checks++; if (ev_valid1 !== 1'b1) $display("FAIL mid_valid got %b want 1", ev_valid1); else passes++;
      Reset = 1'b1;
      nin1 = 5'b11111;
      @(negedge Clock);
      checks++; if (ev_valid1 !== 1'b0 || ev_count1 !== 4'd0 || stable1 !== 5'b0) $display("FAIL mid_reset valid %b count %0d stable %b want 0 0 0", ev_valid1, ev_count1, stable1); else passes++;
      Reset = 1'b0;
      repeat (15) @(negedge Clock);
      checks++; if (ev_valid1 !== 1'b0) $display("FAIL mid_after got %b want 0", ev_valid1); else passes++;
   endtask

`ifdef TIMESTAMP_EN
   task automatic test_timestamp();
      logic [15:0] s1, s2;
      s1 = 16'd0;
      s2 = 16'd0;
      nin1[4] = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (press1[4]) begin s1 = tb_cyc; break; end
      end
      repeat (4) @(negedge Clock);
      nin1[4] = 1'b1;
      repeat (60) @(negedge Clock);
      nin1[4] = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge Clock);
         if (press1[4]) begin s2 = tb_cyc; break; end
      end
      repeat (4) @(negedge Clock);
      nin1[4] = 1'b1;
      repeat (12) @(negedge Clock);
      checks++; if (ev_count1 !== 4'd4) $display("FAIL ts_count got %0d want 4", ev_count1); else passes++;
      checks++; if (ev_data1 !== {3'd4, 2'b00, s1}) $display("FAIL ts_first got %h want %h", ev_data1, {3'd4, 2'b00, s1}); else passes++;
      pop1();
      pop1();
      checks++; if (ev_data1 !== {3'd4, 2'b00, s2}) $display("FAIL ts_second got %h want %h", ev_data1, {3'd4, 2'b00, s2}); else passes++;
      pop1();
      pop1();
   endtask
`endif

   // Hard stop if the sequence ever stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      Reset      = 1'b1;
      nin1       = 5'b11111;
      nin2       = 5'b11111;
      ev_ready1  = 1'b0;
      ev_ready2  = 1'b0;
      ovf_clear1 = 1'b0;
      ovf_clear2 = 1'b0;
      test_reset();
      test_press_latency();
      test_glitch();
      test_long_press();
      test_simultaneous();
      test_overflow();
      test_reset_mid();
`ifdef TIMESTAMP_EN
      test_timestamp();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
